// File: rtl/pio_in_edge_capture.sv
// WIDTH-bit synchronized input PIO on an Avalon-MM slave with registered read data.
// Define PIO_IN_EDGE_IRQ_EN to build edge capture (W1C), irq mask and the irq output.
module pio_in_edge_capture #(
    parameter int WIDTH     = 8,
    parameter int EDGE_MODE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
`ifdef PIO_IN_EDGE_IRQ_EN
    output logic             irq,
`endif
    output logic [31:0]      readdata
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [31:0]      r_readdata;
    logic [31:0]      w_data_ext;
    logic [31:0]      w_read_mux;

    // r_sync2 is the metastability-safe copy of in_port and doubles as data_in.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_data_ext             = '0;
        w_data_ext[WIDTH-1:0]  = r_sync2;
    end

`ifdef PIO_IN_EDGE_IRQ_EN
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_write;
    logic [31:0]      w_mask_ext;
    logic [31:0]      w_capture_ext;
    logic             w_unused;

    assign w_write  = chipselect & ~write_n;
    assign w_unused = ^writedata;

    always_comb begin
        case (EDGE_MODE)
            1:       w_edge = ~r_sync2 & r_prev;
            2:       w_edge = r_sync2 ^ r_prev;
            default: w_edge = r_sync2 & ~r_prev;
        endcase
    end

    always_comb begin
        w_clr = '0;
        if (w_write && (address == 2'd3)) begin
            w_clr = writedata[WIDTH-1:0];
        end
    end

    // A newly detected edge wins over a write-1-to-clear on the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev         <= '0;
            r_edge_capture <= '0;
            r_irq_mask     <= '0;
        end else begin
            r_prev         <= r_sync2;
            r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge;
            if (w_write && (address == 2'd2)) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_mask_ext                = '0;
        w_mask_ext[WIDTH-1:0]     = r_irq_mask;
        w_capture_ext             = '0;
        w_capture_ext[WIDTH-1:0]  = r_edge_capture;
    end

    assign irq = |(r_edge_capture & r_irq_mask);
`else
    logic w_unused;

    assign w_unused = ^{writedata, chipselect, write_n, (EDGE_MODE == 0)};
`endif

    always_comb begin
        w_read_mux = '0;
        case (address)
            2'd0:    w_read_mux = w_data_ext;
`ifdef PIO_IN_EDGE_IRQ_EN
            2'd2:    w_read_mux = w_mask_ext;
            2'd3:    w_read_mux = w_capture_ext;
`endif
            default: w_read_mux = '0;
        endcase
    end

    // Reads are unconditional: the mux is registered every cycle regardless of chipselect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_read_mux;
        end
    end

    assign readdata = r_readdata;

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Self-checking bench for pio_in_edge_capture: three instances (rising/8, falling/8, any/3)
// share one Avalon bus; expected values go through a scoreboard queue.
module tb_pio_in_edge_capture;

`ifdef PIO_IN_EDGE_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    logic        clk;
    logic        resetN;
    logic [1:0]  address;
    logic        chipselect;
    logic        writeN;
    logic [31:0] writedata;
    logic [7:0]  inPortA;
    logic [2:0]  inPortB;
    logic [31:0] rdA;
    logic [31:0] rdB;
    logic [31:0] rdC;
`ifdef PIO_IN_EDGE_IRQ_EN
    logic        irqA;
    logic        irqB;
    logic        irqC;
`endif

    int assertCount = 0;
    int failCount   = 0;
    logic [31:0] expQ[$];

    typedef struct {
        logic [7:0]  inPort;
        bit          doWrite;
        logic [1:0]  wrAddr;
        logic [31:0] wrData;
        logic [1:0]  rdAddr;
        logic [31:0] expOn;
        logic        expIrq;
        logic [31:0] expOff;
    } vector_t;

    vector_t vecs[15];

    pio_in_edge_capture #(.WIDTH(8), .EDGE_MODE(0)) dutA (
        .clk(clk), .reset_n(resetN), .address(address), .chipselect(chipselect),
        .write_n(writeN), .writedata(writedata), .in_port(inPortA),
`ifdef PIO_IN_EDGE_IRQ_EN
        .irq(irqA),
`endif
        .readdata(rdA)
    );

    pio_in_edge_capture #(.WIDTH(3), .EDGE_MODE(2)) dutB (
        .clk(clk), .reset_n(resetN), .address(address), .chipselect(chipselect),
        .write_n(writeN), .writedata(writedata), .in_port(inPortB),
`ifdef PIO_IN_EDGE_IRQ_EN
        .irq(irqB),
`endif
        .readdata(rdB)
    );

    pio_in_edge_capture #(.WIDTH(8), .EDGE_MODE(1)) dutC (
        .clk(clk), .reset_n(resetN), .address(address), .chipselect(chipselect),
        .write_n(writeN), .writedata(writedata), .in_port(inPortA),
`ifdef PIO_IN_EDGE_IRQ_EN
        .irq(irqC),
`endif
        .readdata(rdC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Everything is driven and sampled on the falling edge, away from the active edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busIdle();
        chipselect = 1'b0;
        writeN     = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        writeN     = 1'b0;
        address    = a;
        writedata  = d;
        tick(1);
        busIdle();
    endtask

    task automatic busRead(input logic [1:0] a);
        chipselect = 1'b1;
        writeN     = 1'b1;
        address    = a;
        writedata  = 32'h0;
        tick(1);
    endtask

    task automatic pushExpect(input logic [31:0] v);
        expQ.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual);
        logic [31:0] expVal;
        assertCount++;
        if (expQ.size() == 0) begin
            failCount++;
            $display("[TB] FAIL %s: scoreboard empty, actual %h", name, actual);
        end else begin
            expVal = expQ.pop_front();
            if (actual !== expVal) begin
                failCount++;
                $display("[TB] FAIL %s: actual %h required %h", name, actual, expVal);
            end
        end
    endtask

    // Settle the input for three edges (sync + capture), optional write, then one read.
    task automatic applyStimulus(input vector_t v, input int idx);
        inPortA = v.inPort;
        busIdle();
        tick(3);
        if (v.doWrite) begin
            busWrite(v.wrAddr, v.wrData);
        end
        pushExpect(IRQ_BUILT ? v.expOn : v.expOff);
`ifdef PIO_IN_EDGE_IRQ_EN
        pushExpect({31'b0, v.expIrq});
`endif
        busRead(v.rdAddr);
        checkOutput($sformatf("vec%0d readdata", idx), rdA);
`ifdef PIO_IN_EDGE_IRQ_EN
        checkOutput($sformatf("vec%0d irq", idx), {31'b0, irqA});
`endif
    endtask

    initial begin
        //                inPort  wr    wrAddr wrData         rdAddr expOn         irq   expOff
        vecs[0]  = '{8'hFF, 1'b1, 2'd3, 32'h0000_00FF, 2'd3, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[1]  = '{8'h00, 1'b0, 2'd0, 32'h0000_0000, 2'd3, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[2]  = '{8'h05, 1'b0, 2'd0, 32'h0000_0000, 2'd3, 32'h0000_0005, 1'b0, 32'h0000_0000};
        vecs[3]  = '{8'h05, 1'b1, 2'd2, 32'h0000_0004, 2'd2, 32'h0000_0004, 1'b1, 32'h0000_0000};
        vecs[4]  = '{8'h05, 1'b1, 2'd3, 32'h0000_0004, 2'd3, 32'h0000_0001, 1'b0, 32'h0000_0000};
        vecs[5]  = '{8'h05, 1'b0, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0005, 1'b0, 32'h0000_0005};
        vecs[6]  = '{8'h05, 1'b1, 2'd0, 32'h0000_00FF, 2'd0, 32'h0000_0005, 1'b0, 32'h0000_0005};
        vecs[7]  = '{8'h05, 1'b1, 2'd1, 32'h0000_00FF, 2'd1, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[8]  = '{8'hF5, 1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_00FF, 1'b1, 32'h0000_0000};
        vecs[9]  = '{8'hF5, 1'b0, 2'd0, 32'h0000_0000, 2'd3, 32'h0000_00F1, 1'b1, 32'h0000_0000};
        vecs[10] = '{8'hF5, 1'b1, 2'd3, 32'h0000_00F1, 2'd3, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[11] = '{8'hA0, 1'b0, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_00A0, 1'b0, 32'h0000_00A0};
        vecs[12] = '{8'h5F, 1'b0, 2'd0, 32'h0000_0000, 2'd3, 32'h0000_005F, 1'b1, 32'h0000_0000};
        vecs[13] = '{8'h5F, 1'b1, 2'd2, 32'h0000_0000, 2'd3, 32'h0000_005F, 1'b0, 32'h0000_0000};
        vecs[14] = '{8'h5F, 1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000, 1'b0, 32'h0000_0000};

        resetN  = 1'b0;
        inPortA = 8'hFF;
        inPortB = 3'b000;
        busIdle();
        tick(3);
        pushExpect(32'h0);
        checkOutput("reset readdata", rdA);
`ifdef PIO_IN_EDGE_IRQ_EN
        pushExpect(32'h0);
        checkOutput("reset irq", {31'b0, irqA});
`endif
        resetN = 1'b1;
        tick(2);
        pushExpect(32'h0);
        checkOutput("data before sync settles", rdA);
        tick(1);
        pushExpect(32'h0000_00FF);
        checkOutput("data two cycles after reset", rdA);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i], i);
        end

`ifdef PIO_IN_EDGE_IRQ_EN
        // Bit 1 rises so its capture sets on the same edge as a W1C of that bit.
        inPortA = 8'h5D;
        busIdle();
        tick(3);
        inPortA = 8'h5F;
        tick(2);
        busWrite(2'd3, 32'h2);
        pushExpect(32'h2);
        busRead(2'd3);
        checkOutput("edge beats clear", rdA);
        busWrite(2'd3, 32'h2);
        pushExpect(32'h0);
        busRead(2'd3);
        checkOutput("clear without edge", rdA);
`endif

        // Four-cycle pulse on bit 0 seen by rising (A), falling (C) and any (B) instances.
        inPortA = 8'h00;
        inPortB = 3'b000;
        resetN  = 1'b0;
        busIdle();
        tick(2);
        resetN = 1'b1;
        tick(3);
        inPortA = 8'h01;
        inPortB = 3'b001;
        tick(3);
        busRead(2'd3);
        pushExpect(IRQ_BUILT ? 32'h1 : 32'h0);
        checkOutput("rise: rising mode", rdA);
        pushExpect(32'h0);
        checkOutput("rise: falling mode", rdC);
        pushExpect(IRQ_BUILT ? 32'h1 : 32'h0);
        checkOutput("rise: any mode", rdB);
        inPortA = 8'h00;
        inPortB = 3'b000;
        busIdle();
        tick(3);
        busRead(2'd3);
        pushExpect(IRQ_BUILT ? 32'h1 : 32'h0);
        checkOutput("fall: rising mode", rdA);
        pushExpect(IRQ_BUILT ? 32'h1 : 32'h0);
        checkOutput("fall: falling mode", rdC);
        pushExpect(IRQ_BUILT ? 32'h1 : 32'h0);
        checkOutput("fall: any mode", rdB);
`ifdef PIO_IN_EDGE_IRQ_EN
        pushExpect(32'h0);
        checkOutput("unmasked irq stays low", {31'b0, irqC});
`endif

        // Narrow instance: zero extension of data and mask.
        inPortB = 3'b111;
        busIdle();
        tick(3);
        busWrite(2'd2, 32'hFFFF_FFFF);
        pushExpect(32'h7);
        busRead(2'd0);
        checkOutput("narrow data zero-extended", rdB);
        pushExpect(IRQ_BUILT ? 32'h7 : 32'h0);
        busRead(2'd2);
        checkOutput("narrow mask zero-extended", rdB);
        pushExpect(32'h0);
        busRead(2'd1);
        checkOutput("narrow reserved reads 0", rdB);
`ifdef PIO_IN_EDGE_IRQ_EN
        pushExpect(32'h1);
        checkOutput("narrow irq", {31'b0, irqB});

        // Mid-operation reset drops mask and captures; held-high input recaptures later.
        resetN = 1'b0;
        busIdle();
        tick(1);
        resetN = 1'b1;
        pushExpect(32'h0);
        busRead(2'd2);
        checkOutput("mask lost after reset", rdB);
        tick(1);
        pushExpect(32'h0);
        busRead(2'd3);
        checkOutput("capture lost after reset", rdB);
        pushExpect(32'h7);
        busRead(2'd3);
        checkOutput("held input recaptured", rdB);
        pushExpect(32'h0);
        checkOutput("irq low with cleared mask", {31'b0, irqB});
`endif

        busIdle();
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pio_in_edge_capture.md
# pio_in_edge_capture

Parametrised input PIO for the lightweight HPS-to-FPGA bus, the next generation of the single-bit ready/status input port. It samples a WIDTH-bit input bus through a two-flop synchronizer and exposes the level on a 32-bit Avalon-MM slave. It latches edges into a write-1-to-clear capture register and can raise a maskable interrupt to the HPS. It sits between fabric status signals (ready flags, done strobes, VGA/M10K handshake lines) and the Qsys interconnect.

## Interface
- WIDTH, 8: number of input bits, legal range 1..32.
- EDGE_MODE, 0: edge type captured; 0 = rising, 1 = falling, 2 = any.
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- address  input  2  Avalon word address.
- chipselect  input  1  Avalon slave select.
- write_n  input  1  active-low write strobe; qualified by chipselect.
- writedata  input  32  write data; bits [WIDTH-1:0] are used.
- in_port  input  WIDTH  asynchronous fabric inputs.
- readdata  output  32  registered read data, zero-extended above WIDTH.
- irq  output  1  level interrupt, active high (present only with the macro, see Configuration).

## Operation
- Reset is synchronous and active-low. While reset_n=0 at a clk edge, the following registers are cleared on that edge: sync1, sync2, prev, edge_capture, irq_mask, and readdata. irq=0.
- Synchronizer: sync1 <= in_port; sync2 <= sync1; prev <= sync2. data_in = sync2.
- Edge detect, per bit i, evaluated every cycle:
  - rising: sync2[i] & ~prev[i]
  - falling: ~sync2[i] & prev[i]
  - any: sync2[i] ^ prev[i]
- Register map, word addresses:
  - 0 data: read-only; returns data_in. Writes are ignored.
  - 1 reserved: reads 0; writes are ignored.
  - 2 irq_mask: read/write, bits [WIDTH-1:0].
  - 3 edge_capture: a read returns the latched edges. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- Write strobe: a write occurs on a cycle with chipselect=1 and write_n=0.
- Capture set/clear precedence, per bit: next = (capture & ~clr) | edge, where clr = writedata bit when writing address 3, else 0. A detected edge wins over a simultaneous clear.
- readdata is updated every cycle from the address mux, independent of chipselect. Bits [31:WIDTH] are always 0.
- irq = |(edge_capture & irq_mask). It is driven combinationally from registered state, so it is glitch-free.

## Timing
- Read latency is 1 cycle. readdata at edge N+1 reflects the address and register state present at edge N.
- Input to data register: an in_port change that is setup-valid before edge E0 appears in data_in after E1. It is readable on readdata after E2.
- Input to capture: the edge is detected during the cycle after E1. The edge_capture bit sets at E2. irq rises in the same cycle that the capture bit is set.
- Write to readback: an irq_mask or edge_capture write at edge W is visible in register state after W. A read issued at W+1 returns the new value at W+2.
- Clear with no new edge: the capture bit is 0 after W, and irq deasserts in the same cycle.
- Pulses shorter than one clk period may be missed. This is acceptable; it is not an error.
- Reset mid-operation: pending captures and the mask are lost. The synchronizer restarts from 0, so an input held high after reset reads as a rising edge two cycles later (EDGE_MODE 0/2).

## Configuration
- PIO_IN_EDGE_IRQ_EN defined:
  - edge detect, edge_capture, irq_mask, and the irq port are all built.
  - Addresses 2 and 3 behave as described in Operation.
- PIO_IN_EDGE_IRQ_EN undefined:
  - only the synchronizer and the data register are built.
  - Addresses 1–3 read 0, and all writes are ignored.
  - The irq port is absent.
  - Read latency and data timing are unchanged.

## Test plan
- Reset and idle: hold reset_n=0 for 3 cycles with in_port=8'hFF. Deassert, then read address 0 two cycles later → 32'h000000FF. Before that, readdata=0 and irq=0.
- Rising capture (WIDTH=8, EDGE_MODE=0): step in_port 8'h00→8'h05. Expect edge_capture=8'h05 two edges after sampling. Write address 2 = 8'h04 → irq=1. Write 8'h04 to address 3 → capture reads 8'h01 and irq=0.
- Clear vs edge collision: raise in_port bit 1 so that its capture sets on the same edge as a write of 32'h2 to address 3 → bit 1 remains 1 on readback.
- Falling / any modes: with EDGE_MODE=1, pulse bit 0 high for 4 cycles → capture sets only at the fall. With EDGE_MODE=2, the same pulse sets the capture once, and it stays 1 after the second edge.
- Width/zero-extension (WIDTH=3): drive in_port=3'b111 and set mask 32'hFFFFFFFF → readdata at addresses 0 and 2 are 32'h7, and address 1 reads 0.
- Macro off: write 32'hFF to addresses 2 and 3, then read addresses 1–3 → all 0. Address 0 still tracks in_port with 2-cycle sync plus 1-cycle read latency.
